// File: rtl/booth_dot_ctrl_if.sv
// Stream, multiplier and result signals of the Booth dot-product sequencer.
// slave is the sequencer's view; master is the surrounding system (source, multiplier, sink).
interface booth_dot_ctrl_if #(
  parameter int ACC_W = 24
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both 1; a valid source keeps its payload stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;

  logic             mul_start;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic             mul_valid;
  logic [15:0]      mul_z;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             ovf;
  logic             err;

  logic [1:0]       dbg_state;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_valid, mul_z, out_ready,
    output in_ready, mul_start, mul_x, mul_y, out_valid, out_data, ovf, err, dbg_state
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_valid, mul_z, out_ready,
    input  in_ready, mul_start, mul_x, mul_y, out_valid, out_data, ovf, err, dbg_state
  );
endinterface

// File: rtl/booth_dot_ctrl.sv
// Sequences signed operand pairs into an external 8x8 Booth multiplier one term at a
// time and accumulates the products into a dot product released on the last term.
module booth_dot_ctrl #(
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  booth_dot_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_mul_start;
  logic [7:0]         r_mul_x;
  logic [7:0]         r_mul_y;
  logic               r_last;
  logic [7:0]         r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic               r_out_valid;
  logic               r_ovf;
  logic               r_err;

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic               w_sum_ovf;
  logic               w_timeout;

  assign w_prod_ext = ACC_W'($signed(bus.mul_z));
  assign w_sum      = r_acc + w_prod_ext;
  // Two's-complement overflow: addends share a sign the wrapped sum does not.
  assign w_sum_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_timeout  = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_mul_start <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mul_x     <= bus.in_a;
            r_mul_y     <= bus.in_b;
            r_last      <= bus.in_last;
            r_in_ready  <= 1'b0;
            r_mul_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_mul_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end

        S_WAIT: begin
          // A result landing in the final counted cycle still beats the timeout.
          if (bus.mul_valid || w_timeout) begin
            if (bus.mul_valid) begin
              r_acc <= w_sum;
              if (w_sum_ovf) r_ovf <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            if (r_last) begin
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_in_ready  <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_mul_start <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator only moves outside OUT, so it doubles as the held result.
  assign bus.in_ready  = r_in_ready;
  assign bus.mul_start = r_mul_start;
  assign bus.mul_x     = r_mul_x;
  assign bus.mul_y     = r_mul_y;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_booth_dot_ctrl.sv
// Bench for booth_dot_ctrl: 16- and 24-bit instances share stimulus and a behavioural
// multiplier; results are compared with an arithmetic reference of the dot product.
module tb_booth_dot_ctrl;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a      = 8'd0;
  logic [7:0]  in_b      = 8'd0;
  logic        spur_v    = 1'b0;
  logic [15:0] spur_z    = 16'd0;

  logic        mdl_v;
  logic [15:0] mdl_z;
  logic        mdl_pend;
  int          mdl_dly;
  int          lat = 5;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          start_base;

  longint      ref16 = 0;
  longint      ref24 = 0;
  logic        rov16 = 1'b0;
  logic        rov24 = 1'b0;
  logic        rerr  = 1'b0;
  logic [7:0]  cur_a = 8'd0;
  logic [7:0]  cur_b = 8'd0;
  logic [15:0] out_hold;

  booth_dot_ctrl_if #(.ACC_W(16)) bus16 ();
  booth_dot_ctrl_if #(.ACC_W(24)) bus24 ();

  assign bus16.in_valid  = in_valid;
  assign bus16.in_a      = in_a;
  assign bus16.in_b      = in_b;
  assign bus16.in_last   = in_last;
  assign bus16.out_ready = out_ready;
  assign bus16.mul_valid = mdl_v | spur_v;
  assign bus16.mul_z     = spur_v ? spur_z : mdl_z;
  assign bus24.in_valid  = in_valid;
  assign bus24.in_a      = in_a;
  assign bus24.in_b      = in_b;
  assign bus24.in_last   = in_last;
  assign bus24.out_ready = out_ready;
  assign bus24.mul_valid = mdl_v | spur_v;
  assign bus24.mul_z     = spur_v ? spur_z : mdl_z;

  booth_dot_ctrl #(.ACC_W(16), .TIMEOUT(TMO)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  booth_dot_ctrl #(.ACC_W(24), .TIMEOUT(TMO)) dut24 (.clk(clk), .rst(rst), .bus(bus24));

  // Behavioural multiplier: answers lat cycles after the cycle it sees mul_start.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_pend <= 1'b0;
      mdl_v    <= 1'b0;
      mdl_z    <= 16'd0;
      mdl_dly  <= 0;
    end else begin
      mdl_v <= 1'b0;
      if (bus16.mul_start) begin
        mdl_pend <= 1'b1;
        mdl_dly  <= lat - 1;
        mdl_z    <= $signed({{8{bus16.mul_x[7]}}, bus16.mul_x}) *
                    $signed({{8{bus16.mul_y[7]}}, bus16.mul_y});
      end else if (mdl_pend) begin
        if (mdl_dly == 0) begin
          mdl_v    <= 1'b1;
          mdl_pend <= 1'b0;
        end else begin
          mdl_dly <= mdl_dly - 1;
        end
      end
    end
  end

  always @(posedge clk) if (bus16.mul_start === 1'b1) start_cnt <= start_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_to(input longint v, input int w);
    longint m, h;
    m = longint'(1) <<< w;
    h = m / 2;
    v = v % m;
    if (v >= h) v = v - m;
    else if (v < -h) v = v + m;
    return v;
  endfunction

  task automatic ref_add(input longint p);
    if ((ref16 + p) > 32767 || (ref16 + p) < -32768) rov16 = 1'b1;
    if ((ref24 + p) > 8388607 || (ref24 + p) < -8388608) rov24 = 1'b1;
    ref16 = wrap_to(ref16 + p, 16);
    ref24 = wrap_to(ref24 + p, 24);
  endtask

  task automatic ref_clear();
    ref16 = 0; ref24 = 0; rov16 = 1'b0; rov24 = 1'b0; rerr = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    while (bus16.in_ready !== 1'b1 && n < 60) begin
      chk("mul_x_hold", bus16.mul_x, cur_a);
      chk("mul_y_hold", bus16.mul_y, cur_b);
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", bus16.in_ready, 1);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("start_pulse", bus16.mul_start, 1);
    chk("start_pulse24", bus24.mul_start, 1);
    chk("mul_x_capt", bus16.mul_x, a);
    chk("mul_y_capt", bus16.mul_y, b);
    chk("in_ready_busy", bus16.in_ready, 0);
    @(negedge clk);
    chk("start_one_cycle", bus16.mul_start, 0);
    cur_a = a; cur_b = b;
    if (lat < TMO) ref_add(longint'($signed(a)) * longint'($signed(b)));
    else rerr = 1'b1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 80) begin
      chk("mul_x_hold", bus16.mul_x, cur_a);
      @(negedge clk);
      n++;
    end
    chk("out_valid", bus16.out_valid, 1);
    chk("out_valid24", bus24.out_valid, 1);
  endtask

  task automatic chk_result();
    chk("out_data16", $signed(bus16.out_data), ref16);
    chk("out_data24", $signed(bus24.out_data), ref24);
    chk("ovf16", bus16.ovf, rov16);
    chk("ovf24", bus24.ovf, rov24);
    chk("err16", bus16.err, rerr);
    chk("err24", bus24.err, rerr);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", bus16.out_valid, 0);
    chk("in_ready_after", bus16.in_ready, 1);
    chk("acc_cleared", bus16.out_data, 0);
    chk("ovf_cleared", bus16.ovf, 0);
    chk("err_cleared", bus16.err, 0);
    ref_clear();
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst_mul_start", bus16.mul_start, 0);
    chk("rst_mul_x", bus16.mul_x, 0);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_out_data", bus16.out_data, 0);
    chk("rst_ovf", bus16.ovf, 0);
    chk("rst_err", bus16.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic two-term sum
    lat = 5;
    start_base = start_cnt;
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'hFE, 8'd5, 1'b1);
    wait_valid();
    chk("basic_sum_const", $signed(bus24.out_data), 2);
    chk_result();
    chk("basic_starts", start_cnt - start_base, 2);
    accept();

    // Single term, most negative operands
    start_base = start_cnt;
    send_pair(8'h80, 8'h80, 1'b1);
    wait_valid();
    chk("single_const", $signed(bus24.out_data), 16384);
    chk_result();
    chk("single_starts", start_cnt - start_base, 1);
    accept();

    // Overflow in the 16-bit instance
    for (int i = 0; i < 3; i++) send_pair(8'd127, 8'd127, i == 2);
    wait_valid();
    chk("ovf_const", $signed(bus16.out_data), -17149);
    chk_result();
    accept();

    // Result in the final counted cycle wins; one cycle later it times out
    lat = TMO - 1;
    send_pair(8'd1, 8'd1, 1'b1);
    wait_valid();
    chk_result();
    accept();
    lat = TMO;
    send_pair(8'd1, 8'd1, 1'b1);
    wait_valid();
    chk("late_err", bus16.err, 1);
    chk_result();
    accept();

    // Multiplier never answers, then a spurious result pulse in OUT
    lat = 1000;
    send_pair(8'd1, 8'd1, 1'b1);
    wait_valid();
    chk_result();
    spur_v = 1'b1; spur_z = 16'h1234;
    @(negedge clk);
    spur_v = 1'b0;
    chk("spur_ignored", $signed(bus16.out_data), 0);
    chk_result();
    accept();

    // Backpressure with a pending pair on the input
    lat = 3;
    send_pair(8'd10, 8'hFD, 1'b1);
    wait_valid();
    chk_result();
    out_hold = bus16.out_data;
    start_base = start_cnt;
    in_a = 8'd9; in_b = 8'd9; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", bus16.out_valid, 1);
      chk("bp_data", bus16.out_data, out_hold);
      chk("bp_in_ready", bus16.in_ready, 0);
    end
    in_valid = 1'b0;
    chk_result();
    chk("bp_no_capture", start_cnt - start_base, 0);
    accept();

    // Reset between clock edges during WAIT
    lat = 6;
    send_pair(8'd5, 8'd5, 1'b0);
    send_pair(8'd7, 8'd7, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_in_ready", bus16.in_ready, 1);
    chk("mrst_mul_start", bus16.mul_start, 0);
    chk("mrst_mul_x", bus16.mul_x, 0);
    chk("mrst_mul_y", bus16.mul_y, 0);
    chk("mrst_out_valid", bus16.out_valid, 0);
    chk("mrst_out_data", bus16.out_data, 0);
    chk("mrst_ovf", bus16.ovf, 0);
    chk("mrst_err", bus16.err, 0);
    @(negedge clk);
    rst = 1'b1;
    ref_clear();
    cur_a = 8'd0; cur_b = 8'd0;
    lat = 5;
    send_pair(8'd2, 8'd3, 1'b1);
    wait_valid();
    chk("after_rst_const", $signed(bus24.out_data), 6);
    chk_result();
    accept();

    // Randomised sums, occasional timeouts and sink stalls
    for (int s = 0; s < 15; s++) begin
      int nt;
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        lat = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(1, TMO - 1);
        send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), t == nt - 1);
      end
      wait_valid();
      chk_result();
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_stall_valid", bus16.out_valid, 1);
      end
      chk_result();
      accept();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_dot_ctrl.md
Name: booth_dot_ctrl

Overview:
- Operand sequencer and accumulator wrapped around the 8x8 Booth multiplier.
- Accepts signed operand pairs over a valid/ready stream and issues each pair to the multiplier as a one-cycle start pulse.
- Consumes the multiplier's valid/Z result and accumulates the signed products into a dot product.
- Emits the sum on an output valid/ready handshake when the pair tagged last completes.

Parameters:
ACC_W, 24, accumulator and result width in bits (signed two's complement, 16 to 32).
TIMEOUT, 32, number of WAIT cycles without mul_valid before the term is abandoned (2 to 255).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-low reset; 0 clears all state immediately
in_valid  input  1  operand pair available
in_ready  output  1  block can accept a pair this cycle
in_a  input  8  signed operand A
in_b  input  8  signed operand B
in_last  input  1  pair is final term of the current dot product
mul_start  output  1  one-cycle start pulse to the multiplier
mul_x  output  8  multiplicand to the multiplier, held from capture until the term completes
mul_y  output  8  multiplier operand, held from capture until the term completes
mul_valid  input  1  multiplier result-valid pulse
mul_z  input  16  multiplier signed product
out_valid  output  1  dot-product result valid
out_ready  input  1  downstream accepts the result
out_data  output  ACC_W  accumulated dot product
ovf  output  1  sticky: signed overflow occurred in the current sum
err  output  1  sticky: a term timed out in the current sum

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, in_ready=1, mul_start=0, mul_x=mul_y=0, out_valid=0, out_data=0, ovf=0, err=0.
  - Accumulator=0, timeout counter=0, captured last flag=0.
- Reset release: synchronous to clk.
- Reset mid-operation: abandons the in-flight term and the partial sum. No result is emitted.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_a->mul_x, in_b->mul_y and in_last, then go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly this cycle; in_ready=0.
  - Timeout counter cleared. Next state WAIT.
- WAIT:
  - in_ready=0; counter increments each cycle.
  - On mul_valid: acc <= acc + sign_extend(mul_z to ACC_W).
    - Set ovf if the operand signs agree and the result sign differs.
    - Go to OUT if the captured last flag is set, else IDLE.
  - If the counter reaches TIMEOUT-1 with no mul_valid: set err, leave acc unchanged, then go to OUT if last, else IDLE.
  - If mul_valid arrives in that same final cycle, it wins: accumulate, no err.
- OUT:
  - out_valid=1; out_data=acc; in_ready=0; ovf and err visible.
  - On out_ready: acc, ovf and err clear, then go to IDLE (new pair accepted next cycle).
  - out_data, ovf and err must stay stable while out_valid=1 and out_ready=0.
- Handshakes:
  - mul_valid outside WAIT is ignored.
  - mul_x and mul_y do not change between capture and leaving WAIT.
  - Only one term is in flight at a time.
  - A single-term sum (in_last on the first pair) is legal.
- Arithmetic: accumulation wraps modulo 2^ACC_W. ovf is sticky until the result is accepted.
- Throughput: one term per (multiplier latency + 3) cycles; no back-to-back issue.

Test Plan:
- Basic: pairs (3,4), (-2,5, last) with a behavioural 5-cycle multiplier -> two mul_start pulses; out_data=2; ovf=0; err=0.
- Single term: (-128,-128, last) -> out_data=16384 with ACC_W=24; one mul_start pulse; mul_x=0x80 stable through WAIT.
- Overflow: ACC_W=16, three pairs (127,127), last on the third -> out_data=-17149 (0xBD03); ovf=1. After out_ready, the next sum starts with ovf=0 and acc=0.
- Timeout: TIMEOUT=8, multiplier never answers, (1,1, last) -> after 8 WAIT cycles out_valid=1, out_data=0, err=1. A spurious mul_valid asserted afterwards does not change out_data.
- Backpressure: hold out_ready=0 for 10 cycles with a result pending -> out_valid stays 1, out_data stable, in_ready=0, and in_valid pairs are not captured. Release -> IDLE the next cycle.
- Reset mid-WAIT: drive rst=0 between clock edges -> outputs reach reset values without a clock edge. After release, the new sum (2,3, last) gives out_data=6.
